// File: rtl/axi_slv_pkg.sv
// Shared types and codes for the AXI write slave: response/burst encodings,
// FSM state enum, beat-count type and the latched AW header.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_slv_pkg;

  localparam int ID_W = `AXI_IDS_BITS;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_e;

  typedef logic [3:0] beat_cnt_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    beat_cnt_t       len;
    logic [2:0]      size;
    logic [1:0]      burst;
  } aw_hdr_t;

  // DECERR outranks SLVERR
  function automatic logic [1:0] bresp_code(input logic dec_err, input logic slv_err);
    if (dec_err)      return RESP_DECERR;
    else if (slv_err) return RESP_SLVERR;
    else              return RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next beat address for FIXED / INCR / WRAP bursts (reserved 11 behaves as INCR).
// Latency: combinational. Backpressure: none, pure function of its inputs.
// The wrap block is (len+1)<<size bytes, aligned to its own size.
module axi_burst_addr_gen
  import axi_slv_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic [2:0]  size,
  input  beat_cnt_t   len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  always_comb begin
    step      = 32'd1 << size;
    incr_addr = cur_addr + step;
    wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      BURST_FIXED: next_addr = cur_addr;
      BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_slave_write.sv
// AXI write slave, one outstanding burst, writing beats straight into a word memory port.
// Latency: mem write same cycle as each W beat; B one cycle after last beat; AWREADY after B.
// Backpressure: W gaps stall freely, BREADY low holds B. Option: AXI_SLV_WLAST_CHK_EN.
module axi_slave_write
  import axi_slv_pkg::*;
#(
  parameter logic [31:0] MEM_BASE = 32'h0001_0000,
  parameter int          MEM_AW   = 14
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [`AXI_IDS_BITS-1:0]  AWID,
  input  logic [31:0]               AWADDR,
  input  logic [3:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [31:0]               WDATA,
  input  logic [3:0]                WSTRB,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [`AXI_IDS_BITS-1:0]  BID,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      mem_we,
  output logic [MEM_AW-1:0]         mem_addr,
  output logic [31:0]               mem_wdata,
  output logic [3:0]                mem_wstrb
);

  localparam logic [32:0] WIN_LO = {1'b0, MEM_BASE};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'd4 << MEM_AW);

  wr_state_e   state, state_nxt;
  aw_hdr_t     aw_q;
  logic [31:0] cur_addr;
  logic [31:0] next_addr;
  beat_cnt_t   beat_cnt;
  logic        dec_err;
  logic        size_err;
  logic        wlast_err;
  logic        aw_hs;
  logic        w_hs;
  logic        last_beat;
  logic        beat_dec;
  logic        beat_wlast_err;

  function automatic logic out_of_window(input logic [31:0] a);
    return ({1'b0, a} < WIN_LO) || ({1'b0, a} >= WIN_HI);
  endfunction

  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign last_beat = (beat_cnt == aw_q.len);
  // Re-checked every beat so an INCR running off the window top turns DECERR there.
  assign beat_dec  = dec_err | out_of_window(cur_addr);

`ifdef AXI_SLV_WLAST_CHK_EN
  assign beat_wlast_err = (WLAST != last_beat);
`else
  logic wlast_unused;
  assign wlast_unused   = WLAST;
  assign beat_wlast_err = 1'b0;
`endif

  axi_burst_addr_gen u_addr_gen (
    .cur_addr  (cur_addr),
    .size      (aw_q.size),
    .len       (aw_q.len),
    .burst     (aw_q.burst),
    .next_addr (next_addr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (aw_hs)             state_nxt = ST_DATA;
      ST_DATA: if (w_hs && last_beat) state_nxt = ST_RESP;
      ST_RESP: if (BREADY)            state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    AWREADY = (state == ST_IDLE);
    WREADY  = (state == ST_DATA);
    BVALID  = (state == ST_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_q      <= '0;
      cur_addr  <= '0;
      beat_cnt  <= '0;
      dec_err   <= 1'b0;
      size_err  <= 1'b0;
      wlast_err <= 1'b0;
    end else if (aw_hs) begin
      aw_q      <= '{id: AWID, len: AWLEN, size: AWSIZE, burst: AWBURST};
      cur_addr  <= AWADDR;
      beat_cnt  <= '0;
      dec_err   <= out_of_window(AWADDR);
      size_err  <= (AWSIZE > 3'd2);
      wlast_err <= 1'b0;
    end else if (w_hs) begin
      cur_addr  <= next_addr;
      dec_err   <= beat_dec;
      wlast_err <= wlast_err | beat_wlast_err;
      if (!last_beat) beat_cnt <= beat_cnt + 4'd1;
    end
  end

  assign mem_we    = w_hs & ~beat_dec & ~size_err;
  assign mem_addr  = cur_addr[MEM_AW+1:2];
  assign mem_wdata = mem_we ? WDATA : 32'd0;
  assign mem_wstrb = mem_we ? WSTRB : 4'd0;

  assign BID   = aw_q.id;
  assign BRESP = bresp_code(dec_err, size_err | wlast_err);

endmodule
